// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO between the UART receiver and its consumer.
// Ready/valid on both sides, occupancy count and a sticky overflow flag.
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         enq_data,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    output logic [WIDTH-1:0]         deq_data,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointer wrap relies on natural binary rollover, so DEPTH must be 2^n.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_byte_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic full;
    logic empty;
    logic enq_fire;
    logic deq_fire;

    // Handshake flags come from the stored count only; no bypass paths.
    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    assign deq_data  = mem[rd_ptr];
    assign count     = cnt_q;
    assign overflow  = ovf_q;

    // Storage is intentionally not reset; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (enq_fire && reset_n) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            unique case ({enq_fire, deq_fire})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // A new overflow event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (enq_valid && full) begin
            ovf_q <= 1'b1;
        end else if (clear_overflow) begin
            ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Scoreboard bench for uart_byte_fifo (WIDTH=8, DEPTH=16): reference queue
// plus a count/overflow model, compared every cycle on the falling edge.
module tb_uart_byte_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] enq_data;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] deq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [4:0]       count;
    logic             overflow;
    logic             clear_overflow;

    uart_byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enq_data       (enq_data),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .deq_data       (deq_data),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] sb_q [$];
    int         m_cnt;
    logic       m_ovf;
    int         n_deq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive after the rising edge, check and advance the
    // model on the falling edge, before the next rising edge commits.
    task automatic step(input logic ev, input logic [7:0] ed, input logic dr, input logic clr);
        logic e_fire;
        logic d_fire;
        @(posedge clk);
        #1;
        enq_valid      = ev;
        enq_data       = ed;
        deq_ready      = dr;
        clear_overflow = clr;
        @(negedge clk);
        check("count", 32'(count), 32'(m_cnt));
        check("enq_ready", 32'(enq_ready), 32'(m_cnt != DEPTH));
        check("deq_valid", 32'(deq_valid), 32'(m_cnt != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("cnt_range", 32'(count <= 5'd16), 32'd1);
        if (m_cnt != 0 && sb_q.size() > 0) begin
            check("deq_data", 32'(deq_data), 32'(sb_q[0]));
        end
        e_fire = ev && (m_cnt != DEPTH);
        d_fire = dr && (m_cnt != 0);
        if (d_fire) begin
            void'(sb_q.pop_front());
            n_deq++;
        end
        if (e_fire) sb_q.push_back(ed);
        m_cnt = m_cnt + (e_fire ? 1 : 0) - (d_fire ? 1 : 0);
        if (ev && m_cnt == DEPTH && !e_fire && !d_fire) m_ovf = 1'b1;
        else if (ev && !e_fire) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    initial begin
        int pushed;
        int cyc;
        logic ev;
        logic dr;
        reset_n        = 1'b1;
        enq_valid      = 1'b0;
        enq_data       = '0;
        deq_ready      = 1'b0;
        clear_overflow = 1'b0;
        n_deq          = 0;
        model_reset();

        // Power-on reset.
        #2 reset_n = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single word, next-cycle visibility.
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("first_word", 32'(deq_data), 32'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, then one overflowing offer.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd16);
        check("full_ovf", 32'(overflow), 32'd1);

        // Drain in order; overflow remains sticky, then clear it.
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("drained_ovf", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full with both sides active: only the dequeue fires.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_both_cnt", 32'(count), 32'd15);
        // Set beats clear in the same cycle.
        step(1'b1, 8'h90, 1'b0, 1'b1);
        step(1'b1, 8'h91, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("set_wins", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

        // Streaming: count holds at 1, pointers wrap several times.
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("stream_empty", 32'(count), 32'd0);

        // Random traffic, 1000 words through the reference queue.
        pushed = 0;
        cyc    = 0;
        while ((pushed < 1000 || m_cnt != 0) && cyc < 20000) begin
            ev = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            dr = 1'($urandom_range(0, 1));
            if (ev && m_cnt != DEPTH) pushed++;
            step(ev, 8'($urandom_range(0, 255)), dr, 1'b1);
            cyc++;
        end
        if (cyc >= 20000) check("random_timeout", 32'd0, 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Mid-cycle reset with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_deq_valid", 32'(deq_valid), 32'd0);
        check("async_enq_ready", 32'(enq_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        enq_valid = 1'b0;
        @(negedge clk);
        check("post_rst_count", 32'(count), 32'd0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'hA6, 1'b0, 1'b0);
        check("post_rst_head", 32'(deq_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_byte_fifo.md
UART_BYTE_FIFO -- requirements
Module: uart_byte_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of storage entries. The block SHALL support only powers of two that are at least 2.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port enq_data, input, WIDTH: write data from the upstream producer (uart data_out).
REQ-006 Port enq_valid, input, 1: upstream holds a valid word.
REQ-007 Port enq_ready, output, 1: FIFO can accept a word.
REQ-008 Port deq_data, output, WIDTH: head-of-queue word for the downstream consumer (uart data_in).
REQ-009 Port deq_valid, output, 1: deq_data is valid.
REQ-010 Port deq_ready, input, 1: downstream accepts deq_data.
REQ-011 Port count, output, $clog2(DEPTH)+1: number of words currently stored, range 0..DEPTH.
REQ-012 Port overflow, output, 1: sticky flag; set when upstream offered a word while the FIFO was full.
REQ-013 Port clear_overflow, input, 1: synchronous clear for overflow.

Function
REQ-014 Enqueue fire = enq_valid AND enq_ready; dequeue fire = deq_valid AND deq_ready; each fire transfers exactly one word per cycle.
REQ-015 enq_ready SHALL equal (count != DEPTH); it is combinational from state only, with no dependency on deq_ready (no full-pass-through).
REQ-016 deq_valid SHALL equal (count != 0); it is combinational from state only, with no dependency on enq_valid (no empty-bypass).
REQ-017 Show-ahead behaviour: deq_data SHALL present the oldest stored word whenever deq_valid=1, and SHALL hold stable until a dequeue fire.
REQ-018 Latency: a word enqueued in cycle N SHALL be visible on deq_data/deq_valid in cycle N+1 when the FIFO was empty.
REQ-019 Pointers: write and read pointers SHALL each be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-020 Count update per cycle: enqueue only -> +1; dequeue only -> -1; both -> unchanged; neither -> unchanged.
REQ-021 Full with deq_ready=1 and enq_valid=1: only the dequeue fires, and count becomes DEPTH-1.
REQ-022 Empty with enq_valid=1 and deq_ready=1: only the enqueue fires, and count becomes 1.
REQ-023 Ordering: words SHALL dequeue in exactly the order enqueued, with no loss or duplication while no overflow occurs.
REQ-024 Overflow SHALL be set on any cycle with enq_valid=1 AND count==DEPTH; the offered word is not stored.
REQ-025 clear_overflow=1 SHALL clear overflow on the next edge. If a set condition occurs in the same cycle, set SHALL win.
REQ-026 Storage contents are not reset. deq_data is don't-care while deq_valid=0.

Reset
REQ-027 reset_n low SHALL immediately and asynchronously force: pointers=0, count=0, overflow=0, deq_valid=0, enq_ready=1.
REQ-028 Reset asserted mid-transfer SHALL discard all stored words; no fire occurs on the edge where reset_n is low.
REQ-029 Deassertion of reset_n SHALL be synchronised by the system; the first fire is possible on the first rising edge after reset_n is sampled high.

Verification (WIDTH=8, DEPTH=16)
REQ-030 Reset, then enqueue 0x41 with deq_ready=0 -> next cycle: deq_valid=1, deq_data=0x41, count=1.
REQ-031 Enqueue 0x00..0x0F back-to-back with deq_ready=0 -> count=16, enq_ready=0. A 17th offer of 0x10 -> overflow=1, 0x10 is dropped, count stays 16.
REQ-032 From full, hold deq_ready=1 for 16 cycles -> data 0x00..0x0F in order, then deq_valid=0, count=0, overflow still 1. Pulse clear_overflow -> overflow=0.
REQ-033 Continuous enq_valid=1 and deq_ready=1 with an incrementing byte for 40 cycles -> count holds at 1 after the first cycle, pointers wrap at least twice, and output order matches input order.
REQ-034 Randomised enq_valid/deq_ready (50%) with 1000 words checked against a reference queue -> zero mismatches, count always in 0..16.
REQ-035 Load 5 words, assert reset_n low mid-cycle -> count=0, deq_valid=0, enq_ready=1 immediately (before the next edge). After release, the first dequeued word is the first word enqueued after reset.
